ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the FPGA to the keyboard over the shared open-collector clock/data lines. It sits next to the keyboard receiver on the same `ps2c`/`ps2d` pins. It performs the request-to-send inhibit, shifts out data, parity and stop bits on device-generated clock edges, and checks the device acknowledge. While `busy` is high, the receiver's output is not valid.

---
 rtl/ps2_host_tx_if.sv | 11 +
 rtl/ps2_host_tx.sv | 155 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a controller and the PS/2 host transmitter
interface ps2_host_tx_if;
  logic       start;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       err_timeout;
  modport master (output start, din, input busy, done, ack_ok, err_timeout);
  modport slave (input start, din, output busy, done, ack_ok, err_timeout);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with request-to-send, ACK check and watchdog
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave cmd,
  input  logic         ps2c_in,
  input  logic         ps2d_in,
  output logic         ps2c_oe,
  output logic         ps2d_oe
);
  localparam int MAX_CYCLES = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW = $clog2(MAX_CYCLES + 1);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] REQ       = 3'd2;
  localparam logic [2:0] SHIFT     = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shreg_q, shreg_d;
  logic [2:0]    c_sync_q, c_sync_d;
  logic [1:0]    d_sync_q, d_sync_d;
  logic          ps2c_oe_q, ps2c_oe_d;
  logic          ps2d_oe_q, ps2d_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_ok_q, ack_ok_d;
  logic          err_q, err_d;
  logic          fall, wd;
  // c_sync_q[1] is the synchronized clock, [2] its previous value for edge detection
  assign fall = c_sync_q[2] & ~c_sync_q[1];
  assign wd = (state_q inside {REQ, SHIFT, ACK, WAIT_IDLE}) && tmr_q == TW'(TIMEOUT_CYCLES - 1);
  assign ps2c_oe = ps2c_oe_q;
  assign ps2d_oe = ps2d_oe_q;
  assign cmd.busy = busy_q;
  assign cmd.done = done_q;
  assign cmd.ack_ok = ack_ok_q;
  assign cmd.err_timeout = err_q;
  // next-state: frame sequencing on device clock falls, with the watchdog overriding every waiting state
  always_comb begin
    c_sync_d = {c_sync_q[1:0], ps2c_in};
    d_sync_d = {d_sync_q[0], ps2d_in};
    state_d = state_q;
    tmr_d = tmr_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shreg_d = shreg_q;
    ps2c_oe_d = 1'b0;
    ps2d_oe_d = ps2d_oe_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ack_ok_d = ack_ok_q;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        busy_d = 1'b0;
        ps2d_oe_d = 1'b0;
        if (cmd.start && !busy_q) begin
          state_d = INHIBIT;
          shreg_d = {~^cmd.din, cmd.din};
          ack_ok_d = 1'b0;
          err_d = 1'b0;
          busy_d = 1'b1;
          ps2c_oe_d = 1'b1;
          ps2d_oe_d = INHIBIT_CYCLES <= 10;
        end
      end
      INHIBIT: begin
        ps2c_oe_d = 1'b1;
        ps2d_oe_d = int'(tmr_d) >= INHIBIT_CYCLES - 10;
        if (tmr_q == TW'(INHIBIT_CYCLES - 1)) begin
          state_d = REQ;
          tmr_d = '0;
          ps2c_oe_d = 1'b0;
          ps2d_oe_d = 1'b1;
        end
      end
      REQ: begin
        if (fall) begin
          state_d = SHIFT;
          tmr_d = '0;
          bit_cnt_d = 4'd1;
          ps2d_oe_d = ~shreg_q[0];
        end
      end
      SHIFT: begin
        if (fall) begin
          tmr_d = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          ps2d_oe_d = bit_cnt_q == 4'd9 ? 1'b0 : ~shreg_q[bit_cnt_q];
          state_d = bit_cnt_q == 4'd9 ? ACK : SHIFT;
        end
      end
      ACK: begin
        if (fall) begin
          state_d = WAIT_IDLE;
          tmr_d = '0;
          ack_ok_d = ~d_sync_q[1];
          ps2d_oe_d = 1'b0;
        end
      end
      WAIT_IDLE: begin
        ps2d_oe_d = 1'b0;
        if (c_sync_q[1] && d_sync_q[1]) begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wd) begin
      state_d = IDLE;
      ps2c_oe_d = 1'b0;
      ps2d_oe_d = 1'b0;
      err_d = 1'b1;
      ack_ok_d = 1'b0;
      done_d = 1'b1;
    end
  end
  // state registers; reset releases both lines at once and parks the synchronizers high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tmr_q <= '0;
      bit_cnt_q <= '0;
      shreg_q <= '0;
      c_sync_q <= '1;
      d_sync_q <= '1;
      ps2c_oe_q <= 1'b0;
      ps2d_oe_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ack_ok_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q <= shreg_d;
      c_sync_q <= c_sync_d;
      d_sync_q <= d_sync_d;
      ps2c_oe_q <= ps2c_oe_d;
      ps2d_oe_q <= ps2d_oe_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ack_ok_q <= ack_ok_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model on the open-collector lines
module tb_ps2_host_tx;
  localparam int INH = 50;
  localparam int TMO = 2000;
  localparam int H = 20;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dev_c = 1'b0;
  logic dev_d = 1'b0;
  logic ps2c_oe, ps2d_oe, ps2c_pin, ps2d_pin;
  int total = 0;
  int bad = 0;
  ps2_host_tx_if cmd_if ();
  assign ps2c_pin = ~(ps2c_oe | dev_c);
  assign ps2d_pin = ~(ps2d_oe | dev_d);
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if),
    .ps2c_in(ps2c_pin), .ps2d_in(ps2d_pin),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe)
  );
  always #5 clk = ~clk;
  initial begin
    #600000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse_start(input logic [7:0] b);
    @(negedge clk);
    cmd_if.start = 1'b1;
    cmd_if.din = b;
    @(negedge clk);
    cmd_if.start = 1'b0;
  endtask
  task automatic send_start(input logic [7:0] b);
    pulse_start(b);
    check("busy_rise", cmd_if.busy, 1);
  endtask
  // device side: time the inhibit, then clock nf falling edges, sampling data on each rise
  task automatic dev_xfer(input int nf, input bit ack, output logic [10:0] fr, output int inh, output logic drel);
    int g;
    fr = '0;
    inh = 0;
    drel = 1'b0;
    g = 0;
    while (ps2c_oe !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    while (ps2c_oe === 1'b1 && inh < 10000) begin
      drel = ps2d_oe;
      inh++;
      @(negedge clk);
    end
    fr[0] = ps2d_pin;
    repeat (H) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      dev_c = 1'b1;
      repeat (H) @(negedge clk);
      if (k == nf && nf < 11) return;
      if (k == 11) begin
        dev_c = 1'b0;
        dev_d = 1'b0;
        return;
      end
      dev_c = 1'b0;
      fr[k] = ps2d_pin;
      repeat (H) @(negedge clk);
      if (k == 10 && ack) dev_d = 1'b1;
    end
  endtask
  task automatic wait_done(input int lim, output int n, output logic a, output logic e);
    n = 0;
    while (cmd_if.done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", cmd_if.done, 1);
    check("busy_at_done", cmd_if.busy, 1);
    a = cmd_if.ack_ok;
    e = cmd_if.err_timeout;
    @(negedge clk);
    check("done_pulse", cmd_if.done, 0);
    check("busy_fall", cmd_if.busy, 0);
  endtask
  task automatic xfer(input logic [7:0] b, input bit ack, input logic [10:0] exp_fr, input bit inj);
    logic [10:0] fr;
    int inh, n;
    logic drel, a, e;
    send_start(b);
    fork
      dev_xfer(11, ack, fr, inh, drel);
      if (inj) begin
        repeat (300) @(negedge clk);
        pulse_start(8'h01);
      end
    join
    check("frame", fr, exp_fr);
    check("inhibit_len", inh, INH);
    check("data_low_at_release", drel, 1);
    wait_done(2000, n, a, e);
    check("ack_ok", a, ack);
    check("err_timeout", e, 0);
    repeat (5) @(negedge clk);
    check("idle_busy", cmd_if.busy, 0);
    check("ack_hold", cmd_if.ack_ok, ack);
  endtask
  initial begin
    logic [10:0] fr;
    int inh, n;
    logic drel, a, e;
    cmd_if.start = 1'b0;
    cmd_if.din = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ps2c_oe", ps2c_oe, 0);
    check("rst_ps2d_oe", ps2d_oe, 0);
    check("rst_busy", cmd_if.busy, 0);
    check("rst_done", cmd_if.done, 0);
    check("rst_ack", cmd_if.ack_ok, 0);
    check("rst_err", cmd_if.err_timeout, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    xfer(8'hF4, 1'b1, 11'h5E8, 1'b0);
    xfer(8'hED, 1'b1, 11'h7DA, 1'b0);
    send_start(8'h3C);
    wait_done(INH + TMO + 100, n, a, e);
    check("tmo_cycles", n, INH + TMO);
    check("tmo_ack", a, 0);
    check("tmo_err", e, 1);
    check("tmo_ps2c_oe", ps2c_oe, 0);
    check("tmo_ps2d_oe", ps2d_oe, 0);
    xfer(8'hF4, 1'b0, 11'h5E8, 1'b0);
    xfer(8'hF4, 1'b1, 11'h5E8, 1'b1);
    xfer(8'h01, 1'b1, 11'h402, 1'b0);
    send_start(8'hA5);
    dev_xfer(4, 1'b1, fr, inh, drel);
    repeat (H / 2) @(negedge clk);
    check("pre_rst_busy", cmd_if.busy, 1);
    check("pre_rst_ps2d_oe", ps2d_oe, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ps2c_oe", ps2c_oe, 0);
    check("async_rst_ps2d_oe", ps2d_oe, 0);
    check("async_rst_busy", cmd_if.busy, 0);
    check("async_rst_done", cmd_if.done, 0);
    dev_c = 1'b0;
    dev_d = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    xfer(8'h5A, 1'b1, 11'h6B4, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
